rd_sched: RTL and testbench
===========================

Name: rd_sched

Overview:
- Round-robin scheduler that shares the single packet read controller between N_REQ capture sources.
- Each source presents a packet descriptor (word address, byte length). rd_sched arbitrates, validates the descriptor, issues it to the read controller with a one-cycle start pulse, and waits for the controller's ready/done.
- A watchdog bounds the wait. Each source receives an ack, with an error flag when needed.
- Sits between the capture front-ends and the read controller in the tcpdump datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max cycles in WAIT before abort (>=2)
MAX_LEN, 1518, largest legal packet length in bytes

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = grants allowed; 0 = finish in-flight job, then no new grants
req  in  N_REQ  per-source request, held until req_ack
req_addr  in  32*N_REQ  descriptor address, source i at bits [32*i+31:32*i]
req_len  in  32*N_REQ  descriptor byte length, same packing
req_ack  out  N_REQ  one-cycle completion pulse to granted source
req_err  out  N_REQ  qualifies req_ack: 1 = rejected or timed out
rd_start  out  1  one-cycle start pulse to read controller
rd_addr  out  32  latched descriptor address, stable from ISSUE through WAIT
rd_len  out  32  latched descriptor length, stable from ISSUE through WAIT
rd_ctrl_rdy  in  1  read controller done; sampled only in WAIT
busy  out  1  state != IDLE
grant_id  out  $clog2(N_REQ)  index of current/last granted source
pkt_count  out  32  successful transfers, wraps at 2^32
timeout_count  out  16  watchdog aborts, saturates at 16'hFFFF

Behaviour:
- Reset values: state=IDLE; req_ack=0; req_err=0; rd_start=0; rd_addr=0; rd_len=0; busy=0; grant_id=N_REQ-1; pkt_count=0; timeout_count=0; watchdog=0. Source 0 therefore wins the first arbitration.
- FSM states: IDLE, ISSUE, WAIT, RELEASE. All outputs are registered.
- IDLE:
  - If enable and any req: pick the first asserted req scanning from grant_id+1 (mod N_REQ).
  - Latch grant_id, rd_addr and rd_len from the winner.
  - Validate. A descriptor is invalid if len==0, len>MAX_LEN, or addr[1:0]!=0.
  - Valid -> ISSUE. Invalid -> RELEASE with error set.
- ISSUE: rd_start=1 for exactly this cycle; clear watchdog; -> WAIT.
- WAIT:
  - rd_ctrl_rdy=1 -> RELEASE, no error, pkt_count+1.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 -> RELEASE with error, timeout_count+1 (saturating).
  - rd_ctrl_rdy in the same cycle as expiry: done wins, no error.
- RELEASE: req_ack[grant_id]=1 and req_err[grant_id]=error for one cycle; -> IDLE. All other req_ack/req_err bits are 0.
- Latency:
  - Valid descriptor: req seen in IDLE at cycle t -> rd_start at t+1 -> WAIT from t+2. rd_ctrl_rdy at cycle d -> req_ack at d+1.
  - Invalid descriptor: req_ack+req_err at t+1, no rd_start.
- Requester rules:
  - Hold req, addr and len stable until ack.
  - Drop req on the cycle after ack. A req still high in the IDLE cycle after RELEASE counts as a new request, subject to round robin.
- rd_ctrl_rdy outside WAIT is ignored.
- enable=0 only blocks the IDLE->grant transition. An in-flight job completes normally.
- Reset mid-operation returns everything to reset values at the next edge. No ack is given for the aborted job, and rd_start stays low.

Test Plan:
- Reset, then req[2]=1 (addr 0x1000, len 64), rd_ctrl_rdy 5 cycles after rd_start -> rd_start 1 cycle after req, rd_addr=0x1000, rd_len=64, req_ack[2] with req_err[2]=0 one cycle after rdy, pkt_count=1.
- req=4'b1111 held and re-asserted, each job done after 3 cycles -> grant order 0,1,2,3,0; exactly one rd_start per job.
- Invalid descriptors on source 1: len=0, then len=1519, then addr=0x1002 -> each gets req_ack[1]+req_err[1] one cycle after sampling; rd_start never asserted; pkt_count unchanged.
- TIMEOUT_CYCLES=16, rd_ctrl_rdy never asserted -> req_err pulse after 16 cycles in WAIT, timeout_count=1, then next request accepted. Repeat with rdy on the expiry cycle -> no error, pkt_count+1.
- Drop enable during WAIT with req[3] pending -> current job acks; no grant while enable=0; grant to 3 one cycle after enable=1.
- Assert reset in WAIT -> next edge: busy=0, no req_ack, counters 0, grant_id=N_REQ-1.

Source files
------------

// File: rtl/rd_sched.sv
// rd_sched: round-robin arbiter sharing one packet read controller among N_REQ sources, with watchdog.
module rd_sched #(
    parameter int N_REQ = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_LEN = 1518
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    input  logic [32*N_REQ-1:0]      req_addr,
    input  logic [32*N_REQ-1:0]      req_len,
    output logic [N_REQ-1:0]         req_ack,
    output logic [N_REQ-1:0]         req_err,
    output logic                     rd_start,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_len,
    input  logic                     rd_ctrl_rdy,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [31:0]              pkt_count,
    output logic [15:0]              timeout_count
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;
    state_t state;
    logic [WW-1:0] wd;
    logic [IW-1:0] win;
    logic [31:0] win_addr, win_len;
    logic valid;
    int idx;
    always_comb begin
        win = grant_id;
        idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(grant_id) + k) % N_REQ;
            if (req[IW'(idx)]) win = IW'(idx);
        end
    end
    assign win_addr = req_addr[32*int'(win) +: 32];
    assign win_len  = req_len[32*int'(win) +: 32];
    assign valid = (win_len != 32'd0) && (win_len <= 32'(MAX_LEN)) && (win_addr[1:0] == 2'b00);
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ack       <= '0;
            req_err       <= '0;
            rd_start      <= 1'b0;
            rd_addr       <= '0;
            rd_len        <= '0;
            busy          <= 1'b0;
            grant_id      <= IW'(N_REQ - 1);
            pkt_count     <= '0;
            timeout_count <= '0;
            wd            <= '0;
        end else begin
            rd_start <= 1'b0;
            req_ack  <= '0;
            req_err  <= '0;
            case (state)
                IDLE: if (enable && |req) begin
                    grant_id <= win;
                    rd_addr  <= win_addr;
                    rd_len   <= win_len;
                    busy     <= 1'b1;
                    rd_start <= valid;
                    state    <= valid ? ISSUE : RELEASE;
                    req_ack  <= valid ? '0 : N_REQ'(1) << win;
                    req_err  <= valid ? '0 : N_REQ'(1) << win;
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: if (rd_ctrl_rdy) begin
                    state     <= RELEASE;
                    req_ack   <= N_REQ'(1) << grant_id;
                    pkt_count <= pkt_count + 32'd1;
                end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                    state   <= RELEASE;
                    req_ack <= N_REQ'(1) << grant_id;
                    req_err <= N_REQ'(1) << grant_id;
                    if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                end else begin
                    wd <= wd + 1'b1;
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rd_sched.sv
// tb_rd_sched: vector table plus ack scoreboard for rd_sched with a 16-cycle watchdog.
module tb_rd_sched;
    logic clk = 1'b0;
    logic reset, enable, rd_ctrl_rdy, rd_start, busy;
    logic [3:0] req, req_ack, req_err;
    logic [127:0] req_addr, req_len;
    logic [31:0] rd_addr, rd_len, pkt_count;
    logic [1:0] grant_id;
    logic [15:0] timeout_count;
    rd_sched #(.N_REQ(4), .TIMEOUT_CYCLES(16), .MAX_LEN(1518)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req), .req_addr(req_addr),
        .req_len(req_len), .req_ack(req_ack), .req_err(req_err), .rd_start(rd_start),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_ctrl_rdy(rd_ctrl_rdy), .busy(busy),
        .grant_id(grant_id), .pkt_count(pkt_count), .timeout_count(timeout_count)
    );
    always #5 clk = ~clk;
    typedef struct {
        int src;
        logic [31:0] addr;
        logic [31:0] len;
        int dly;
        logic err;
        logic start;
    } vec_t;
    typedef struct {
        logic [3:0] ack;
        logic [3:0] err;
    } exp_t;
    vec_t tbl[8];
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0, starts = 0;
    int n, s0, exp_pkt, exp_to;
    logic [1:0] g;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    always @(negedge clk) if (rd_start) starts++;
    always @(negedge clk) begin
        if (!reset && (req_ack != 4'd0 || req_err != 4'd0)) begin
            if (q.size() == 0) chk("spurious_ack", {24'd0, req_ack, req_err}, 32'd0);
            else begin
                e = q.pop_front();
                chk("ack_mask", {28'd0, req_ack}, {28'd0, e.ack});
                chk("err_mask", {28'd0, req_err}, {28'd0, e.err});
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{2, 32'h1000, 32'd64,   5,  1'b0, 1'b1};
        tbl[1] = '{1, 32'h2000, 32'd0,    0,  1'b1, 1'b0};
        tbl[2] = '{1, 32'h2000, 32'd1519, 0,  1'b1, 1'b0};
        tbl[3] = '{1, 32'h1002, 32'd100,  0,  1'b1, 1'b0};
        tbl[4] = '{1, 32'h3000, 32'd1518, 3,  1'b0, 1'b1};
        tbl[5] = '{3, 32'h4000, 32'd1,    16, 1'b0, 1'b1};
        tbl[6] = '{0, 32'h5000, 32'd200,  -1, 1'b1, 1'b1};
        tbl[7] = '{0, 32'h6000, 32'd4,    1,  1'b0, 1'b1};
        reset = 1'b1; enable = 1'b1; rd_ctrl_rdy = 1'b0;
        req = '0; req_addr = '0; req_len = '0;
        repeat (2) tick;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_gid", {30'd0, grant_id}, 32'd3);
        chk("rst_addr", rd_addr, 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_to", {16'd0, timeout_count}, 32'd0);
        reset = 1'b0;
        exp_pkt = 0; exp_to = 0; s0 = starts;
        for (int i = 0; i < 8; i++) begin
            req_addr[32*tbl[i].src +: 32] = tbl[i].addr;
            req_len[32*tbl[i].src +: 32] = tbl[i].len;
            req[tbl[i].src] = 1'b1;
            q.push_back('{4'd1 << tbl[i].src, tbl[i].err ? 4'd1 << tbl[i].src : 4'd0});
            tick;
            if (tbl[i].start) begin
                chk("start", {31'd0, rd_start}, 32'd1);
                chk("addr", rd_addr, tbl[i].addr);
                chk("len", rd_len, tbl[i].len);
                chk("gid", {30'd0, grant_id}, tbl[i].src);
                if (tbl[i].dly >= 0) begin
                    repeat (tbl[i].dly) tick;
                    rd_ctrl_rdy = 1'b1;
                    tick;
                    rd_ctrl_rdy = 1'b0;
                    chk("ack_lat", {31'd0, |req_ack}, 32'd1);
                    exp_pkt++;
                end else begin
                    n = 0;
                    while (!(|req_ack) && n < 40) begin tick; n++; end
                    chk("wd_cycles", n, 32'd17);
                    exp_to++;
                end
            end else begin
                chk("rej_lat", {31'd0, |req_ack}, 32'd1);
            end
            req[tbl[i].src] = 1'b0;
            tick;
            chk("pkt_count", pkt_count, exp_pkt);
            chk("timeout_count", {16'd0, timeout_count}, exp_to);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        chk("tbl_starts", starts - s0, 32'd5);
        reset = 1'b1; tick; tick; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_addr[32*k +: 32] = 32'h1000 * (k + 1);
            req_len[32*k +: 32] = 32'd64 + k;
        end
        req = 4'b1111; s0 = starts;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            while (!rd_start && n < 10) begin tick; n++; end
            chk("rr_start", {31'd0, rd_start}, 32'd1);
            chk("rr_gid", {30'd0, grant_id}, j % 4);
            chk("rr_addr", rd_addr, 32'h1000 * (j % 4 + 1));
            q.push_back('{4'd1 << (j % 4), 4'd0});
            repeat (3) tick;
            rd_ctrl_rdy = 1'b1;
            tick;
            rd_ctrl_rdy = 1'b0;
            g = grant_id;
            if (j == 4) req = '0; else req[g] = 1'b0;
            tick;
            if (j < 4) req[g] = 1'b1;
        end
        tick;
        chk("rr_starts", starts - s0, 32'd5);
        req[1] = 1'b1;
        q.push_back('{4'b0010, 4'd0});
        tick;
        chk("en_start", {31'd0, rd_start}, 32'd1);
        tick;
        enable = 1'b0; req[3] = 1'b1;
        tick; tick;
        rd_ctrl_rdy = 1'b1;
        tick;
        rd_ctrl_rdy = 1'b0;
        chk("en_ack", {28'd0, req_ack}, 32'b0010);
        req[1] = 1'b0; s0 = starts;
        repeat (4) tick;
        chk("en_busy", {31'd0, busy}, 32'd0);
        chk("en_nogrant", starts - s0, 32'd0);
        q.push_back('{4'b1000, 4'd0});
        enable = 1'b1;
        tick;
        chk("en_start3", {31'd0, rd_start}, 32'd1);
        chk("en_gid3", {30'd0, grant_id}, 32'd3);
        tick;
        rd_ctrl_rdy = 1'b1;
        tick;
        rd_ctrl_rdy = 1'b0; req[3] = 1'b0;
        tick;
        req[2] = 1'b1;
        tick;
        chk("rw_start", {31'd0, rd_start}, 32'd1);
        tick; tick;
        reset = 1'b1;
        tick;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_ack", {28'd0, req_ack}, 32'd0);
        chk("rw_start0", {31'd0, rd_start}, 32'd0);
        chk("rw_pkt", pkt_count, 32'd0);
        chk("rw_to", {16'd0, timeout_count}, 32'd0);
        chk("rw_gid", {30'd0, grant_id}, 32'd3);
        req = '0; reset = 1'b0;
        repeat (3) tick;
        chk("sb_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
